dc_timing_checker: RTL

- Synthesisable, parametrised timing checker for the display-controller (DC) pixel interface: pixel_data, data_valid, hsync, vsync.
- Tracks frame and line structure with an FSM plus counters, and measures the following against parameters:
  - vsync-to-hsync offset
  - hsync pulse width
  - horizontal back porch
  - active pixels per line
  - active lines per frame
- Sits beside the DC-to-DSI bridge input. Raises sticky error flags and single-cycle error pulses, and exposes frame, line and error counts to the bench and to CSR readback.

---
 rtl/dc_pkg.sv | 23 ++
 rtl/dc_crc32.sv | 26 ++
 rtl/dc_timing_checker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dc_pkg.sv
// Shared types and constants for the DC pixel-interface timing checker.
package dc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VS_HS  = 3'd1,
    HSYNC  = 3'd2,
    BPORCH = 3'd3,
    ACTIVE = 3'd4,
    FPORCH = 3'd5
  } dc_state_e;

  localparam int ERR_VS_HS = 0;
  localparam int ERR_HSW   = 1;
  localparam int ERR_HBP   = 2;
  localparam int ERR_HACT  = 3;
  localparam int ERR_VACT  = 4;
  localparam int ERR_NUM   = 5;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/dc_crc32.sv
// One combinational CRC-32 step over a PIXEL_W-bit word, MSB first, no reflection.
module dc_crc32
  import dc_pkg::*;
#(
  parameter int PIXEL_W = 24
) (
  input  logic [31:0]        crc_in,
  input  logic [PIXEL_W-1:0] data,
  output logic [31:0]        crc_out
);

  logic [31:0] crc_acc;

  always_comb begin
    crc_acc = crc_in;
    for (int i = PIXEL_W - 1; i >= 0; i--) begin
      if (crc_acc[31] ^ data[i]) begin
        crc_acc = {crc_acc[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        crc_acc = {crc_acc[30:0], 1'b0};
      end
    end
    crc_out = crc_acc;
  end

endmodule

// File: rtl/dc_timing_checker.sv
// Frame/line timing checker for the DC pixel interface (sync offsets, widths, porch, active sizes).
// Define DC_CHK_CRC_EN to add a per-frame CRC-32 of pixel_data on the frame_crc output.
module dc_timing_checker
  import dc_pkg::*;
#(
  parameter int PIXEL_W  = 24,
  parameter int VS_TO_HS = 0,
  parameter int H_SYNC_W = 5,
  parameter int H_BP     = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 16
) (
  input  logic               dc_clk,
  input  logic               dc_rst,
  input  logic               chk_en,
  input  logic               err_clr,
  input  logic [PIXEL_W-1:0] pixel_data,
  input  logic               data_valid,
  input  logic               hsync,
  input  logic               vsync,
  output logic [ERR_NUM-1:0] err_sticky,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   line_cnt,
  output logic [CNT_W-1:0]   last_hact
`ifdef DC_CHK_CRC_EN
  ,
  output logic [31:0]        frame_crc
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] VS_TO_HS_C = CNT_W'(VS_TO_HS);
  localparam logic [CNT_W-1:0] H_SYNC_W_C = CNT_W'(H_SYNC_W);
  localparam logic [CNT_W-1:0] H_BP_C     = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  dc_state_e            state_q, state_d;
  logic                 vs_q, hs_q, dv_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     line_q, line_d;
  logic [CNT_W-1:0]     frame_q, frame_d;
  logic [CNT_W-1:0]     hact_q, hact_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d, err_cnt_base;
  logic [ERR_NUM-1:0]   sticky_q, sticky_d, new_err;
  logic                 pulse_q, pulse_d;
  logic                 vs_rise, hs_rise, hs_fall, dv_rise, dv_fall;

  // Edges compare the live input with its one-cycle-old copy.
  assign vs_rise = vsync & ~vs_q;
  assign hs_rise = hsync & ~hs_q;
  assign hs_fall = ~hsync & hs_q;
  assign dv_rise = data_valid & ~dv_q;
  assign dv_fall = ~data_valid & dv_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    frame_d = frame_q;
    hact_d  = hact_q;
    new_err = '0;
    if (!chk_en) begin
      state_d = IDLE;
    end else begin
      cnt_d = sat_inc(cnt_q);
      if (vs_rise) begin
        // FPORCH is the only state where a vsync closes a frame; elsewhere it aborts one.
        if (state_q == FPORCH) begin
          if (line_q != V_ACTIVE_C) new_err[ERR_VACT] = 1'b1;
          frame_d = frame_q + 1'b1;
        end else if (state_q != IDLE) begin
          new_err[ERR_VACT] = 1'b1;
        end
        line_d = '0;
        cnt_d  = CNT_ONE;
        if (hs_rise) begin
          if (VS_TO_HS_C != '0) new_err[ERR_VS_HS] = 1'b1;
          state_d = HSYNC;
        end else begin
          state_d = VS_HS;
        end
      end else begin
        case (state_q)
          IDLE: ;
          VS_HS: begin
            if (hs_rise) begin
              if (cnt_q != VS_TO_HS_C) new_err[ERR_VS_HS] = 1'b1;
              state_d = HSYNC;
              cnt_d   = CNT_ONE;
            end
          end
          HSYNC: begin
            if (hs_fall) begin
              if (cnt_q != H_SYNC_W_C) new_err[ERR_HSW] = 1'b1;
              state_d = BPORCH;
              cnt_d   = CNT_ONE;
            end
          end
          BPORCH: begin
            if (dv_rise) begin
              if (cnt_q != H_BP_C) new_err[ERR_HBP] = 1'b1;
              state_d = ACTIVE;
              cnt_d   = CNT_ONE;
            end
          end
          ACTIVE: begin
            if (hs_rise) begin
              new_err[ERR_HACT] = 1'b1;
              hact_d  = cnt_q;
              line_d  = sat_inc(line_q);
              state_d = HSYNC;
              cnt_d   = CNT_ONE;
            end else if (dv_fall) begin
              if (cnt_q != H_ACTIVE_C) new_err[ERR_HACT] = 1'b1;
              hact_d  = cnt_q;
              line_d  = sat_inc(line_q);
              state_d = FPORCH;
            end
          end
          FPORCH: begin
            if (hs_rise) begin
              state_d = HSYNC;
              cnt_d   = CNT_ONE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A coincident clear is applied first, so a fresh error survives it.
  always_comb begin
    sticky_d     = (err_clr ? '0 : sticky_q) | new_err;
    err_cnt_base = err_clr ? '0 : err_cnt_q;
    err_cnt_d    = (|new_err) ? sat_inc(err_cnt_base) : err_cnt_base;
    pulse_d      = |new_err;
  end

  always_ff @(posedge dc_clk or negedge dc_rst) begin
    if (!dc_rst) begin
      state_q   <= IDLE;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      dv_q      <= 1'b0;
      cnt_q     <= '0;
      line_q    <= '0;
      frame_q   <= '0;
      hact_q    <= '0;
      err_cnt_q <= '0;
      sticky_q  <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vsync;
      hs_q      <= hsync;
      dv_q      <= data_valid;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      hact_q    <= hact_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
      pulse_q   <= pulse_d;
    end
  end

  assign err_sticky = sticky_q;
  assign err_pulse  = pulse_q;
  assign err_cnt    = err_cnt_q;
  assign frame_cnt  = frame_q;
  assign line_cnt   = line_q;
  assign last_hact  = hact_q;

`ifdef DC_CHK_CRC_EN
  logic [31:0] crc_run_q, crc_run_d, crc_base, crc_step;
  logic [31:0] frame_crc_q, frame_crc_d;
  logic        frame_end;

  assign frame_end = chk_en & vs_rise & (state_q == FPORCH);
  // Every vsync rise restarts the running CRC; only a clean frame end publishes it.
  assign crc_base  = (chk_en && vs_rise) ? CRC32_INIT : crc_run_q;

  dc_crc32 #(.PIXEL_W(PIXEL_W)) u_crc (
    .crc_in  (crc_base),
    .data    (pixel_data),
    .crc_out (crc_step)
  );

  always_comb begin
    crc_run_d   = crc_run_q;
    frame_crc_d = frame_crc_q;
    if (chk_en) crc_run_d = data_valid ? crc_step : crc_base;
    if (frame_end) frame_crc_d = crc_run_q;
  end

  always_ff @(posedge dc_clk or negedge dc_rst) begin
    if (!dc_rst) begin
      crc_run_q   <= CRC32_INIT;
      frame_crc_q <= '0;
    end else begin
      crc_run_q   <= crc_run_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  logic unused_pixel;
  assign unused_pixel = ^pixel_data;
`endif

endmodule
